// File: rtl/reg_cmd_parser_if.sv
// Bundle of the byte-stream, register-access and transmit signals that
// connect the command parser to its neighbours.
interface reg_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] reg_data;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;
    logic       reg_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;

    // Parser side: consumes rx/reg responses/tx_ready, drives the rest.
    modport slave (
        input  rx_data, rx_valid, reg_rdata, reg_valid, tx_ready,
        output reg_data, reg_write, reg_read, tx_data, tx_valid, busy, err
    );

    // Environment side: byte source, register block and transmitter.
    modport master (
        output rx_data, rx_valid, reg_rdata, reg_valid, tx_ready,
        input  reg_data, reg_write, reg_read, tx_data, tx_valid, busy, err
    );
endinterface

// File: rtl/reg_cmd_parser.sv
// Byte-stream command parser in front of the registers block.
// 'W' addr data writes a register, 'R' addr reads one and returns the byte
// on the transmit handshake (ERR_BYTE if the registers never answer).
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for a command byte
// GET_ADDR | waiting for the address byte
// GET_DATA | waiting for the write data byte
// WR_ADDR  | presenting address with reg_write
// WR_DATA  | presenting write data with reg_write
// RD_REQ   | presenting address with reg_read
// RD_WAIT  | waiting for reg_valid, timeout down-counter running
// TX       | holding tx_data/tx_valid until tx_ready
//
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state they belong to and the latencies are a single clock.
module reg_cmd_parser #(
    parameter logic [7:0]  CMD_WR     = 8'h57,
    parameter logic [7:0]  CMD_RD     = 8'h52,
    parameter int unsigned RD_TIMEOUT = 16,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic           clk,
    input  logic           nRst,
    reg_cmd_parser_if.slave bus
);

    localparam int unsigned   CW      = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WR_ADDR, WR_DATA, RD_REQ, RD_WAIT, TX
    } state_t;

    state_t        state_q, state_nx;
    logic [7:0]    addr_q, addr_nx;
    logic [7:0]    data_q, data_nx;
    logic          is_rd_q, is_rd_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [7:0]    reg_data_q, reg_data_nx;
    logic          reg_write_q, reg_write_nx;
    logic          reg_read_q, reg_read_nx;
    logic [7:0]    tx_data_q, tx_data_nx;
    logic          tx_valid_q, tx_valid_nx;
    logic          busy_q;
    logic          err_q, err_nx;

    assign bus.reg_data  = reg_data_q;
    assign bus.reg_write = reg_write_q;
    assign bus.reg_read  = reg_read_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

    // State, command context and registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            is_rd_q     <= 1'b0;
            cnt_q       <= '0;
            reg_data_q  <= '0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_nx;
            addr_q      <= addr_nx;
            data_q      <= data_nx;
            is_rd_q     <= is_rd_nx;
            cnt_q       <= cnt_nx;
            reg_data_q  <= reg_data_nx;
            reg_write_q <= reg_write_nx;
            reg_read_q  <= reg_read_nx;
            tx_data_q   <= tx_data_nx;
            tx_valid_q  <= tx_valid_nx;
            busy_q      <= (state_nx != IDLE);
            err_q       <= err_nx;
        end
    end

    // Next-state decode and next values of every registered output.
    always_comb begin
        state_nx     = state_q;
        addr_nx      = addr_q;
        data_nx      = data_q;
        is_rd_nx     = is_rd_q;
        cnt_nx       = cnt_q;
        reg_data_nx  = reg_data_q;
        reg_write_nx = 1'b0;
        reg_read_nx  = 1'b0;
        tx_data_nx   = tx_data_q;
        tx_valid_nx  = 1'b0;
        err_nx       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WR) begin
                        is_rd_nx = 1'b0;
                        state_nx = GET_ADDR;
                    end else if (bus.rx_data == CMD_RD) begin
                        is_rd_nx = 1'b1;
                        state_nx = GET_ADDR;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (bus.rx_valid) begin
                    addr_nx = bus.rx_data;
                    if (is_rd_q) begin
                        reg_data_nx = bus.rx_data;
                        reg_read_nx = 1'b1;
                        cnt_nx      = TO_LOAD;
                        state_nx    = RD_REQ;
                    end else begin
                        state_nx = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (bus.rx_valid) begin
                    data_nx      = bus.rx_data;
                    reg_data_nx  = addr_q;
                    reg_write_nx = 1'b1;
                    state_nx     = WR_ADDR;
                end
            end
            WR_ADDR: begin
                err_nx       = bus.rx_valid;
                reg_data_nx  = data_q;
                reg_write_nx = 1'b1;
                state_nx     = WR_DATA;
            end
            WR_DATA: begin
                err_nx   = bus.rx_valid;
                state_nx = IDLE;
            end
            RD_REQ: begin
                err_nx   = bus.rx_valid;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                err_nx = bus.rx_valid;
                // A response on the last counted cycle still beats the timeout.
                if (bus.reg_valid) begin
                    tx_data_nx  = bus.reg_rdata;
                    tx_valid_nx = 1'b1;
                    state_nx    = TX;
                end else if (cnt_q == '0) begin
                    tx_data_nx  = ERR_BYTE;
                    tx_valid_nx = 1'b1;
                    err_nx      = 1'b1;
                    state_nx    = TX;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            TX: begin
                err_nx = bus.rx_valid;
                if (bus.tx_ready) begin
                    state_nx = IDLE;
                end else begin
                    tx_valid_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Bench for reg_cmd_parser: a behavioural register block answers reads
// after a programmable delay, a shadow array predicts read data and the
// expected transmit bytes are queued and matched against captured ones.
module tb_reg_cmd_parser;

    logic clk;
    logic nRst;
    int   total;
    int   bad;

    reg_cmd_parser_if bus ();

    reg_cmd_parser dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register block model state
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    int         rd_delay;
    int         rd_cnt;
    bit         rd_pend;
    logic [7:0] rd_addr;
    bit         wr_phase;
    logic [7:0] wr_addr;
    int         rw_overlap;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         err_cnt;

    // Register block: records write pairs, answers reads after rd_delay cycles.
    always @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_phase      = 1'b0;
            rd_pend       = 1'b0;
            bus.reg_valid = 1'b0;
            bus.reg_rdata = 8'h00;
        end else begin
            bus.reg_valid = 1'b0;
            if (bus.reg_write && bus.reg_read) rw_overlap++;
            if (bus.reg_write) begin
                if (!wr_phase) begin
                    wr_addr  = bus.reg_data;
                    wr_phase = 1'b1;
                end else begin
                    mem[wr_addr] = bus.reg_data;
                    wr_phase     = 1'b0;
                end
            end
            if (rd_pend) begin
                if (rd_cnt <= 1) begin
                    bus.reg_valid = 1'b1;
                    bus.reg_rdata = mem[rd_addr];
                    rd_pend       = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            if (bus.reg_read && rd_delay != 0) begin
                rd_pend = 1'b1;
                rd_cnt  = rd_delay;
                rd_addr = bus.reg_data;
            end
        end
    end

    // Capture bytes accepted by the transmitter.
    always @(posedge clk) begin
        if (nRst && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
    end

    // Count error pulses, one per cycle high.
    always @(negedge clk) begin
        if (nRst && bus.err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
        @(negedge clk);
        @(negedge clk);
        shadow[a] = d;
    endtask

    task automatic do_read(input logic [7:0] a);
        send_byte(8'h52);
        send_byte(a);
        exp_q.push_back(shadow[a]);
    endtask

    task automatic wait_got(output bit ok);
        for (int k = 0; k < 80 && got_q.size() == 0; k++) @(negedge clk);
        ok = (got_q.size() != 0);
    endtask

    task automatic wait_tx_valid(output int n);
        n = 0;
        while (!bus.tx_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [26:0] outs;
        nRst         = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rd_delay     = 3;
        repeat (3) @(negedge clk);
        outs = {bus.reg_data, bus.reg_write, bus.reg_read, bus.tx_data,
                bus.tx_valid, bus.busy, bus.err};
        total++;
        if (outs !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        nRst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int e0;
        e0 = err_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        @(negedge clk);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        total++;
        if (bus.reg_write !== 1'b1 || bus.reg_data !== 8'h10 || bus.reg_read !== 1'b0) begin
            bad++;
            $display("FAIL write_addr_cycle: wr=%b rd=%b data=%h want wr=1 rd=0 data=10",
                     bus.reg_write, bus.reg_read, bus.reg_data);
        end
        @(negedge clk);
        total++;
        if (bus.reg_write !== 1'b1 || bus.reg_data !== 8'hA5) begin
            bad++;
            $display("FAIL write_data_cycle: wr=%b data=%h want wr=1 data=a5",
                     bus.reg_write, bus.reg_data);
        end
        @(negedge clk);
        total++;
        if (bus.reg_write !== 1'b0 || bus.busy !== 1'b0 || bus.reg_data !== 8'hA5) begin
            bad++;
            $display("FAIL write_end: wr=%b busy=%b data=%h want wr=0 busy=0 data=a5",
                     bus.reg_write, bus.busy, bus.reg_data);
        end
        shadow[8'h10] = 8'hA5;
        repeat (3) @(negedge clk);
        total++;
        if (got_q.size() != 0 || bus.tx_valid !== 1'b0 || err_cnt != e0) begin
            bad++;
            $display("FAIL write_no_tx: txq=%0d tx_valid=%b errs=%0d want 0 0 0",
                     got_q.size(), bus.tx_valid, err_cnt - e0);
        end
    endtask

    task automatic test_read();
        int  n;
        int  e0;
        bit  ok;
        logic [7:0] g, x;
        e0           = err_cnt;
        rd_delay     = 3;
        bus.tx_ready = 1'b0;
        do_read(8'h10);
        total++;
        if (bus.reg_read !== 1'b1 || bus.reg_data !== 8'h10 || bus.reg_write !== 1'b0) begin
            bad++;
            $display("FAIL read_req: rd=%b wr=%b data=%h want rd=1 wr=0 data=10",
                     bus.reg_read, bus.reg_write, bus.reg_data);
        end
        @(negedge clk);
        total++;
        if (bus.reg_read !== 1'b0) begin
            bad++;
            $display("FAIL read_req_width: rd=%b want 0", bus.reg_read);
        end
        wait_tx_valid(n);
        n++;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL read_latency: tx_valid after %0d cycles want 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
                bad++;
                $display("FAIL read_hold_%0d: tx_valid=%b tx_data=%h want 1 a5",
                         k, bus.tx_valid, bus.tx_data);
            end
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL read_release: tx_valid=%b busy=%b want 0 0",
                     bus.tx_valid, bus.busy);
        end
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x || err_cnt != e0) begin
            bad++;
            $display("FAIL read_byte: got %h want %h (errs %0d want 0)", g, x, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int  n;
        int  e0;
        bit  ok;
        logic [7:0] g, x;
        e0       = err_cnt;
        rd_delay = 0;
        send_byte(8'h52);
        send_byte(8'h20);
        exp_q.push_back(8'hEE);
        wait_tx_valid(n);
        total++;
        if (n != 17 || bus.err !== 1'b1 || bus.tx_data !== 8'hEE) begin
            bad++;
            $display("FAIL timeout_entry: after %0d cycles err=%b tx_data=%h want 17 1 ee",
                     n, bus.err, bus.tx_data);
        end
        @(negedge clk);
        total++;
        if (bus.tx_valid !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after: tx_valid=%b err=%b want 0 0", bus.tx_valid, bus.err);
        end
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout_byte: got %h errs %0d want %h errs 1", g, err_cnt - e0, x);
        end
    endtask

    task automatic test_timeout_boundary();
        int  e0;
        bit  ok;
        logic [7:0] g, x;
        do_write(8'h21, 8'h3C);
        e0       = err_cnt;
        rd_delay = 16;
        do_read(8'h21);
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x || err_cnt != e0) begin
            bad++;
            $display("FAIL valid_on_last_count: got %h errs %0d want %h errs 0",
                     g, err_cnt - e0, x);
        end
        rd_delay = 17;
        send_byte(8'h52);
        send_byte(8'h21);
        exp_q.push_back(8'hEE);
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL valid_one_late: got %h errs %0d want %h errs 1", g, err_cnt - e0, x);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_bad_overrun();
        int  n;
        int  e0;
        bit  ok;
        logic [7:0] g, x;
        send_byte(8'h33);
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_cmd: err=%b busy=%b want 1 0", bus.err, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL bad_cmd_pulse: err=%b want 0", bus.err);
        end
        do_write(8'h30, 8'h77);
        rd_delay     = 2;
        bus.tx_ready = 1'b0;
        do_read(8'h30);
        wait_tx_valid(n);
        e0 = err_cnt;
        send_byte(8'h44);
        total++;
        if (bus.err !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL overrun_tx: err=%b tx_valid=%b tx_data=%h busy=%b want 1 1 77 1",
                     bus.err, bus.tx_valid, bus.tx_data, bus.busy);
        end
        bus.tx_ready = 1'b1;
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL overrun_byte: got %h errs %0d want %h errs 1", g, err_cnt - e0, x);
        end
    endtask

    task automatic test_sweep();
        bit  ok;
        logic [7:0] g, x, a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            do_write(a, 8'hFF - a);
        end
        for (int i = 0; i < 256; i++) begin
            a        = 8'(i);
            rd_delay = int'($urandom_range(1, 16));
            do_read(a);
            wait_got(ok);
            x = exp_q.pop_front();
            g = ok ? got_q.pop_front() : 8'hxx;
            total++;
            if (!ok || g !== x) begin
                bad++;
                $display("FAIL sweep_addr_%0d: got %h want %h", i, g, x);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [26:0] outs;
        bit  ok;
        logic [7:0] g, x;
        rd_delay = 0;
        send_byte(8'h52);
        send_byte(8'h33);
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_read_busy: busy=%b want 1", bus.busy);
        end
        #2 nRst = 1'b0;
        #1;
        outs = {bus.reg_data, bus.reg_write, bus.reg_read, bus.tx_data,
                bus.tx_valid, bus.busy, bus.err};
        total++;
        if (outs !== 27'd0) begin
            bad++;
            $display("FAIL mid_read_reset: got %h want 0", outs);
        end
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        do_write(8'h03, 8'h5C);
        rd_delay = 2;
        do_read(8'h03);
        wait_got(ok);
        x = exp_q.pop_front();
        g = ok ? got_q.pop_front() : 8'hxx;
        total++;
        if (!ok || g !== x) begin
            bad++;
            $display("FAIL restart_read: got %h want %h", g, x);
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (rw_overlap != 0) begin
            bad++;
            $display("FAIL rd_wr_exclusive: overlaps %0d want 0", rw_overlap);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        err_cnt    = 0;
        rw_overlap = 0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_timeout_boundary();
        test_bad_overrun();
        test_sweep();
        test_reset_mid_read();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
